// File: rtl/phase_timer.sv
// Per-phase elapsed-seconds counter with prescaler, saturation flag and
// time-left / expiry / warning derivation against the active phase length.
module phase_timer #(
    parameter int DIV  = 1,
    parameter int CW   = 5,
    parameter int WARN = 3
) (
    input  logic          clk,
    input  logic          count_reset,
    input  logic          enable,
    input  logic [CW-1:0] max_time,
    output logic [CW-1:0] count_in,
    output logic          sec_tick,
    output logic          sat,
    output logic [CW-1:0] time_left,
    output logic          expired,
    output logic          warn
);

    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0]   CNT_MAX  = '1;
    localparam logic [CW-1:0]   WARN_V   = CW'(WARN);

    logic [PW-1:0] pre;
    logic [CW:0]   diff;

    always_ff @(posedge clk or posedge count_reset) begin
        if (count_reset) begin
            pre      <= '0;
            count_in <= '0;
            sec_tick <= 1'b0;
            sat      <= 1'b0;
        end else if (enable) begin
            if (pre == PRE_LAST) begin
                pre      <= '0;
                sec_tick <= 1'b1;
                if (count_in != CNT_MAX) begin
                    count_in <= count_in + CW'(1);
                    // sat rises on the same edge the count lands on all-ones
                    if (count_in == CNT_MAX - CW'(1)) begin
                        sat <= 1'b1;
                    end
                end else begin
                    sat <= 1'b1;
                end
            end else begin
                pre      <= pre + PW'(1);
                sec_tick <= 1'b0;
            end
        end else begin
            sec_tick <= 1'b0;
        end
    end

    // One extra bit so a count past max_time shows up as a borrow
    assign diff      = {1'b0, max_time} - {1'b0, count_in};
    assign expired   = diff[CW] | (diff[CW-1:0] == '0);
    assign time_left = expired ? '0 : diff[CW-1:0];
    assign warn      = !expired && (time_left <= WARN_V);

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: a DIV=4 and a DIV=1 instance, expected
// ticks queued by the stimulus and popped by per-instance monitors.
module tb_phase_timer;

    localparam int CW = 5;

    typedef struct {
        int cyc;
        int cnt;
        int sat;
    } exp_t;

    logic          clk;
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;

    logic          rst4, en4, tick4, sat4, exp4, warn4;
    logic [CW-1:0] max4, cnt4, tl4;
    logic          rst1, en1, tick1, sat1, exp1, warn1;
    logic [CW-1:0] max1, cnt1, tl1;

    exp_t q4[$];
    exp_t q1[$];

    phase_timer #(.DIV(4), .CW(CW), .WARN(3)) u_div4 (
        .clk(clk), .count_reset(rst4), .enable(en4), .max_time(max4),
        .count_in(cnt4), .sec_tick(tick4), .sat(sat4),
        .time_left(tl4), .expired(exp4), .warn(warn4)
    );

    phase_timer #(.DIV(1), .CW(CW), .WARN(3)) u_div1 (
        .clk(clk), .count_reset(rst1), .enable(en1), .max_time(max1),
        .count_in(cnt1), .sec_tick(tick1), .sat(sat1),
        .time_left(tl1), .expired(exp1), .warn(warn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push4(input int c, input int n, input int s);
        exp_t e;
        e.cyc = c; e.cnt = n; e.sat = s;
        q4.push_back(e);
    endtask

    task automatic push1(input int c, input int n, input int s);
        exp_t e;
        e.cyc = c; e.cnt = n; e.sat = s;
        q1.push_back(e);
    endtask

    always @(negedge clk) begin
        if (tick4 === 1'b1) begin
            if (q4.size() == 0) begin
                check("div4_unexpected_tick", 32'(cnt4), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("div4_tick_cycle", 32'(cyc), 32'(e.cyc));
                check("div4_tick_count", 32'(cnt4), 32'(e.cnt));
                check("div4_tick_sat", 32'(sat4), 32'(e.sat));
            end
        end
    end

    always @(negedge clk) begin
        if (tick1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("div1_unexpected_tick", 32'(cnt1), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("div1_tick_cycle", 32'(cyc), 32'(e.cyc));
                check("div1_tick_count", 32'(cnt1), 32'(e.cnt));
                check("div1_tick_sat", 32'(sat1), 32'(e.sat));
            end
        end
    end

    initial begin
        int c0;
        int d0;
        rst4 = 1'b1; en4 = 1'b0; max4 = 5'd20;
        rst1 = 1'b1; en1 = 1'b0; max1 = 5'd0;
        step(2);

        check("rst_count", 32'(cnt4), 32'd0);
        check("rst_tick", 32'(tick4), 32'd0);
        check("rst_sat", 32'(sat4), 32'd0);

        // max_time=0 in reset, then raised with count_in still 0
        check("max0_expired", 32'(exp1), 32'd1);
        check("max0_time_left", 32'(tl1), 32'd0);
        check("max0_warn", 32'(warn1), 32'd0);
        max1 = 5'd10;
        #1;
        check("max10_time_left", 32'(tl1), 32'd10);
        check("max10_expired", 32'(exp1), 32'd0);

        // DIV=4: ticks every 4 enabled edges, freeze for 10 clks mid-prescale
        c0 = cyc;
        push4(c0 + 4, 1, 0);
        push4(c0 + 8, 2, 0);
        push4(c0 + 12, 3, 0);
        push4(c0 + 26, 4, 0);
        push4(c0 + 30, 5, 0);
        push4(c0 + 34, 6, 0);
        push4(c0 + 38, 7, 0);
        en4 = 1'b1;
        rst4 = 1'b0;
        step(14);
        en4 = 1'b0;
        step(10);
        check("frozen_count", 32'(cnt4), 32'd3);
        check("frozen_tick", 32'(tick4), 32'd0);
        en4 = 1'b1;
        step(16);
        check("pre_reset_count", 32'(cnt4), 32'd7);

        // short reset pulse with pre=2, count_in=7
        rst4 = 1'b1;
        #1;
        check("pulse_count", 32'(cnt4), 32'd0);
        check("pulse_sat", 32'(sat4), 32'd0);
        check("pulse_tick", 32'(tick4), 32'd0);
        rst4 = 1'b0;
        push4(c0 + 44, 1, 0);
        step(4);
        en4 = 1'b0;
        check("post_pulse_count", 32'(cnt4), 32'd1);

        // DIV=1: saturation at 31 and time-left / warn thresholds vs max_time=20
        max1 = 5'd20;
        d0 = cyc;
        for (int i = 1; i <= 40; i++) begin
            push1(d0 + i, (i < 31) ? i : 31, (i >= 31) ? 1 : 0);
        end
        en1 = 1'b1;
        rst1 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            case (i)
                16: begin
                    check("tl_at16", 32'(tl1), 32'd4);
                    check("warn_at16", 32'(warn1), 32'd0);
                    check("exp_at16", 32'(exp1), 32'd0);
                end
                17: begin
                    check("tl_at17", 32'(tl1), 32'd3);
                    check("warn_at17", 32'(warn1), 32'd1);
                end
                19: begin
                    check("tl_at19", 32'(tl1), 32'd1);
                    check("warn_at19", 32'(warn1), 32'd1);
                end
                20: begin
                    check("tl_at20", 32'(tl1), 32'd0);
                    check("exp_at20", 32'(exp1), 32'd1);
                    check("warn_at20", 32'(warn1), 32'd0);
                end
                25: begin
                    check("tl_at25", 32'(tl1), 32'd0);
                    check("exp_at25", 32'(exp1), 32'd1);
                end
                default: ;
            endcase
        end
        en1 = 1'b0;
        step(3);
        check("sat_final_count", 32'(cnt1), 32'd31);
        check("sat_final_flag", 32'(sat1), 32'd1);
        check("div4_queue_drained", 32'(q4.size()), 32'd0);
        check("div1_queue_drained", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
